// File: rtl/rrns_2nrm_pkg.sv
// rrns_2nrm_pkg: constants and types shared by the 2NRM RRNS encoder and decoder.
//   - modulus constants for the two information moduli (257, 256) and the
//     four redundant moduli (61, 59, 55, 53)
//   - bit positions and widths of each residue field in the 64-bit packed word
//   - decoder FSM state encoding
package rrns_2nrm_pkg;

  localparam int unsigned M257 = 257;
  localparam int unsigned M256 = 256;
  localparam int unsigned M61  = 61;
  localparam int unsigned M59  = 59;
  localparam int unsigned M55  = 55;
  localparam int unsigned M53  = 53;

  localparam int R257_MSB = 54;
  localparam int R257_LSB = 46;
  localparam int R257_W   = 9;
  localparam int R256_MSB = 45;
  localparam int R256_LSB = 38;
  localparam int R256_W   = 8;
  localparam int R61_MSB  = 37;
  localparam int R61_LSB  = 32;
  localparam int R59_MSB  = 31;
  localparam int R59_LSB  = 26;
  localparam int R55_MSB  = 25;
  localparam int R55_LSB  = 20;
  localparam int R53_MSB  = 19;
  localparam int R53_LSB  = 14;
  localparam int RRED_W   = 6;

  // Remainder width of the serial reduction and width of the CRT result.
  localparam int REM_W = 7;
  localparam int X_W   = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CRT    = 2'd1,
    REDUCE = 2'd2,
    FINAL  = 2'd3
  } state_e;

endpackage

// File: rtl/rrns_mod_step.sv
// rrns_mod_step: one MSB-first step of a bit-serial modular reduction.
//   rem_out = ((rem_in << 1) | bit_in) reduced once by MOD.
// Ports:
//   rem_in  [6:0]  running remainder, always < MOD
//   bit_in         next bit of the dividend (MSB first)
//   rem_out [6:0]  updated remainder, < MOD
// Because rem_in < MOD, the shifted value is < 2*MOD, so a single
// compare-subtract is enough to bring it back into range.
module rrns_mod_step
  import rrns_2nrm_pkg::*;
#(
  parameter int unsigned MOD = 61
) (
  input  logic [REM_W-1:0] rem_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem_out
);

  logic [REM_W-1:0] shifted_s;

  // rem_in < 64 for every modulus used, so its top bit is always zero and
  // the shift fits back into REM_W bits.
  assign shifted_s = REM_W'({rem_in, bit_in});

  // Conditional subtract of the modulus.
  always_comb begin
    if (shifted_s >= REM_W'(MOD)) begin
      rem_out = shifted_s - REM_W'(MOD);
    end else begin
      rem_out = shifted_s;
    end
  end

endmodule

// File: rtl/decoder_2nrm.sv
// decoder_2nrm: 2NRM RRNS receive-side decoder (error detection only).
// Reconstructs a 16-bit value from residues mod 257 and 256 by CRT, then
// re-derives the residues mod 61/59/55/53 by a 17-cycle bit-serial
// reduction of X and compares them against the received redundant residues.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle request, only looked at in IDLE
//   residues_in    packed residue word (r257, r256, r61, r59, r55, r53)
//   data_out       X[15:0], updated together with done
//   done           one-cycle pulse, all result outputs valid
//   busy           decode in progress
//   err_detect     err_range | err_overflow | |syndrome
//   err_range      some residue field >= its modulus
//   err_overflow   CRT result >= 65536
//   syndrome       [3]=61, [2]=59, [1]=55, [0]=53 residue mismatch
module decoder_2nrm
  import rrns_2nrm_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] residues_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy,
  output logic        err_detect,
  output logic        err_range,
  output logic        err_overflow,
  output logic [3:0]  syndrome
);

  state_e state_r;
  state_e state_nxt_s;

  logic [R257_W-1:0] r257_r;
  logic [R256_W-1:0] r256_r;
  logic [RRED_W-1:0] r61_r;
  logic [RRED_W-1:0] r59_r;
  logic [RRED_W-1:0] r55_r;
  logic [RRED_W-1:0] r53_r;

  logic [X_W-1:0]    x_r;
  logic              range_r;
  logic [4:0]        bit_cnt_r;
  logic [REM_W-1:0]  rem61_r, rem59_r, rem55_r, rem53_r;
  logic [REM_W-1:0]  rem61_nxt_s, rem59_nxt_s, rem55_nxt_s, rem53_nxt_s;

  logic [9:0]        diff_s;
  logic [8:0]        k_s;
  logic [X_W-1:0]    x_s;
  logic              range_s;
  logic              bit_s;
  logic [3:0]        syn_s;
  logic              unused_ignored_s;

  // The packing leaves these bits unassigned; they carry no information.
  assign unused_ignored_s = ^{residues_in[63:55], residues_in[13:0]};

  // k = (r256 - r257) mod 257 via a signed subtract and one conditional +257.
  always_comb begin
    diff_s = {2'b00, r256_r} - {1'b0, r257_r};
    if (diff_s[9]) begin
      k_s = 9'(diff_s + 10'(M257));
    end else begin
      k_s = diff_s[8:0];
    end
  end

  // X = r256 + 256*k is just the concatenation of k above r256.
  assign x_s = {k_s, r256_r};

  assign range_s = (r257_r >= R257_W'(M257)) |
                   (r61_r  >= RRED_W'(M61))  |
                   (r59_r  >= RRED_W'(M59))  |
                   (r55_r  >= RRED_W'(M55))  |
                   (r53_r  >= RRED_W'(M53));

  assign bit_s = x_r[bit_cnt_r];

  rrns_mod_step #(.MOD(M61)) u_step61 (.rem_in(rem61_r), .bit_in(bit_s), .rem_out(rem61_nxt_s));
  rrns_mod_step #(.MOD(M59)) u_step59 (.rem_in(rem59_r), .bit_in(bit_s), .rem_out(rem59_nxt_s));
  rrns_mod_step #(.MOD(M55)) u_step55 (.rem_in(rem55_r), .bit_in(bit_s), .rem_out(rem55_nxt_s));
  rrns_mod_step #(.MOD(M53)) u_step53 (.rem_in(rem53_r), .bit_in(bit_s), .rem_out(rem53_nxt_s));

  // Syndrome from the finished remainders; forced clear when checking is off.
  always_comb begin
    if (CHECK_EN) begin
      syn_s = {rem61_r != {1'b0, r61_r},
               rem59_r != {1'b0, r59_r},
               rem55_r != {1'b0, r55_r},
               rem53_r != {1'b0, r53_r}};
    end else begin
      syn_s = 4'b0000;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CRT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CRT: begin
        if (CHECK_EN) begin
          state_nxt_s = REDUCE;
        end else begin
          state_nxt_s = FINAL;
        end
      end
      REDUCE: begin
        if (bit_cnt_r == 5'd0) begin
          state_nxt_s = FINAL;
        end else begin
          state_nxt_s = REDUCE;
        end
      end
      FINAL:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and registered outputs, sequenced by the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r257_r       <= 9'd0;
      r256_r       <= 8'd0;
      r61_r        <= 6'd0;
      r59_r        <= 6'd0;
      r55_r        <= 6'd0;
      r53_r        <= 6'd0;
      x_r          <= 17'd0;
      range_r      <= 1'b0;
      bit_cnt_r    <= 5'd0;
      rem61_r      <= 7'd0;
      rem59_r      <= 7'd0;
      rem55_r      <= 7'd0;
      rem53_r      <= 7'd0;
      data_out     <= 16'd0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err_detect   <= 1'b0;
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
      syndrome     <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            r257_r <= residues_in[R257_MSB:R257_LSB];
            r256_r <= residues_in[R256_MSB:R256_LSB];
            r61_r  <= residues_in[R61_MSB:R61_LSB];
            r59_r  <= residues_in[R59_MSB:R59_LSB];
            r55_r  <= residues_in[R55_MSB:R55_LSB];
            r53_r  <= residues_in[R53_MSB:R53_LSB];
            busy   <= 1'b1;
          end else begin
            busy   <= 1'b0;
          end
        end
        CRT: begin
          x_r       <= x_s;
          range_r   <= range_s;
          bit_cnt_r <= 5'd16;
          rem61_r   <= 7'd0;
          rem59_r   <= 7'd0;
          rem55_r   <= 7'd0;
          rem53_r   <= 7'd0;
        end
        REDUCE: begin
          rem61_r   <= rem61_nxt_s;
          rem59_r   <= rem59_nxt_s;
          rem55_r   <= rem55_nxt_s;
          rem53_r   <= rem53_nxt_s;
          bit_cnt_r <= bit_cnt_r - 5'd1;
        end
        FINAL: begin
          data_out     <= x_r[15:0];
          syndrome     <= syn_s;
          err_range    <= range_r;
          err_overflow <= x_r[16];
          err_detect   <= range_r | x_r[16] | (|syn_s);
          done         <= 1'b1;
          busy         <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_2nrm.sv
// tb_decoder_2nrm: self-checking bench for decoder_2nrm.
// Drives a table of residue words into a CHECK_EN=1 instance, plus a few
// handshake sequences (ignored start, mid-decode reset) and a CHECK_EN=0
// instance. Expected results are queued at start and popped at done.
module tb_decoder_2nrm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_nc;
  logic [63:0] residues_in, residues_nc;
  logic [15:0] data_out, data_out_nc;
  logic        done, busy, err_detect, err_range, err_overflow;
  logic        done_nc, busy_nc, err_detect_nc, err_range_nc, err_overflow_nc;
  logic [3:0]  syndrome, syndrome_nc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] word;
    logic [15:0] data;
    logic [3:0]  syn;
    logic        det;
    logic        rng;
    logic        ovf;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  decoder_2nrm #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .residues_in(residues_in),
    .data_out(data_out), .done(done), .busy(busy), .err_detect(err_detect),
    .err_range(err_range), .err_overflow(err_overflow), .syndrome(syndrome)
  );

  decoder_2nrm #(.CHECK_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .start(start_nc), .residues_in(residues_nc),
    .data_out(data_out_nc), .done(done_nc), .busy(busy_nc), .err_detect(err_detect_nc),
    .err_range(err_range_nc), .err_overflow(err_overflow_nc), .syndrome(syndrome_nc)
  );

  function automatic logic [63:0] pack(input int a257, input int a256, input int a61,
                                       input int a59, input int a55, input int a53,
                                       input bit junk);
    logic [63:0] w;
    w = 64'd0;
    if (junk) begin
      w[63:55] = 9'h1A5;
      w[13:0]  = 14'h2C3A;
    end
    w[54:46] = 9'(a257);
    w[45:38] = 8'(a256);
    w[37:32] = 6'(a61);
    w[31:26] = 6'(a59);
    w[25:20] = 6'(a55);
    w[19:14] = 6'(a53);
    return w;
  endfunction

  function automatic vec_t mk(input logic [63:0] w, input logic [15:0] d, input logic [3:0] s,
                              input logic det, input logic rng, input logic ovf);
    vec_t v;
    v.word = w; v.data = d; v.syn = s; v.det = det; v.rng = rng; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one start pulse and queue the expected result.
  task automatic launch(input vec_t v, input bit nc);
    if (nc) begin
      residues_nc = v.word;
      start_nc    = 1'b1;
    end else begin
      residues_in = v.word;
      start       = 1'b1;
    end
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    start_nc = 1'b0;
    check("busy_after_start", {31'd0, nc ? busy_nc : busy}, 32'd1);
    check("done_low_after_start", {31'd0, nc ? done_nc : done}, 32'd0);
  endtask

  task automatic wait_done(input bit nc, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if ((nc ? done_nc : done) === 1'b1) break;
    end
  endtask

  // Wait for done and compare every result output against the queued entry.
  task automatic finish_one(input bit nc, input int exp_lat, input string tag);
    int   cyc;
    vec_t e;
    wait_done(nc, 40, cyc);
    check({tag, "_latency"}, cyc, exp_lat);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {16'd0, nc ? data_out_nc : data_out}, {16'd0, e.data});
      check({tag, "_syndrome"}, {28'd0, nc ? syndrome_nc : syndrome}, {28'd0, e.syn});
      check({tag, "_err_detect"}, {31'd0, nc ? err_detect_nc : err_detect}, {31'd0, e.det});
      check({tag, "_err_range"}, {31'd0, nc ? err_range_nc : err_range}, {31'd0, e.rng});
      check({tag, "_err_overflow"}, {31'd0, nc ? err_overflow_nc : err_overflow}, {31'd0, e.ovf});
      check({tag, "_busy_at_done"}, {31'd0, nc ? busy_nc : busy}, 32'd0);
    end
  endtask

  initial begin
    vec_t v1234, verr61, vovf;
    int   extra;
    int   v;

    rst_n = 1'b0; start = 1'b0; start_nc = 1'b0;
    residues_in = 64'd0; residues_nc = 64'd0;

    v1234  = mk(pack(34, 52, 24, 58, 40, 49, 1'b1), 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0);
    verr61 = mk(pack(34, 52, 25, 58, 40, 49, 1'b0), 16'h1234, 4'b1000, 1'b1, 1'b0, 1'b0);
    vovf   = mk(pack(1, 0, 22, 46, 31, 28, 1'b0), 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    vecs.push_back(v1234);
    vecs.push_back(mk(pack(0, 255, 21, 45, 30, 27, 1'b0), 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(pack(0, 0, 0, 0, 0, 0, 1'b0), 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(verr61);
    vecs.push_back(vovf);
    vecs.push_back(mk(pack(300, 52, 24, 58, 40, 49, 1'b0), 16'h0934, 4'b1111, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(pack(34, 52, 24, 58, 40, 60, 1'b1), 16'h1234, 4'b0001, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 65535));
      vecs.push_back(mk(pack(v % 257, v % 256, v % 61, v % 59, v % 55, v % 53, i[0]),
                        16'(v), 4'b0000, 1'b0, 1'b0, 1'b0));
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_detect", {31'd0, err_detect}, 32'd0);
    check("rst_syndrome", {28'd0, syndrome}, 32'd0);
    check("rst_busy_nc", {31'd0, busy_nc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table, issued back-to-back: each start goes in the cycle after done.
    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i], 1'b0);
      finish_one(1'b0, 19, $sformatf("vec%0d", i));
    end

    // Results hold after the done pulse.
    repeat (3) @(negedge clk);
    check("hold_data_out", {16'd0, data_out}, {16'd0, vecs[vecs.size()-1].data});
    check("hold_done_low", {31'd0, done}, 32'd0);

    // start during REDUCE is ignored: one done, for the first word only.
    launch(verr61, 1'b0);
    repeat (5) @(negedge clk);
    residues_in = vecs[1].word;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_one(1'b0, 13, "ignored_start");
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored_start_no_second_done", extra, 32'd0);

    // Reset in the middle of REDUCE aborts the decode.
    launch(v1234, 1'b0);
    repeat (8) @(negedge clk);
    check("busy_mid_reduce", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", {16'd0, data_out}, 32'd0);
    check("midrst_syndrome", {28'd0, syndrome}, 32'd0);
    check("midrst_err_detect", {31'd0, err_detect}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrst_no_done", extra, 32'd0);
    launch(verr61, 1'b0);
    finish_one(1'b0, 19, "after_rst");

    // CHECK_EN=0 build: two-cycle latency, syndrome always clear.
    launch(mk(verr61.word, 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
    finish_one(1'b1, 2, "nc_err61");
    launch(vovf, 1'b1);
    finish_one(1'b1, 2, "nc_ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
